// File: rtl/lab_3_pkg.sv
// rtl/lab_3_pkg.sv - shared types and sizes for the lab_3 self-test sequencer
package lab_3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NUM_VECTORS = 8;
   localparam int VEC_W       = 3;
   localparam int CNT_W       = 4;

endpackage

// File: rtl/lab_3_if.sv
// rtl/lab_3_if.sv - stimulus/response bus between the sequencer and the lab_3 block
interface lab_3_if;

   logic a;
   logic b;
   logic c;
   logic x;
   logic y;

   modport master (output a, output b, output c, input x, input y);
   modport slave  (input a, input b, input c, output x, output y);

endinterface

// File: rtl/lab_3_hold_timer.sv
// rtl/lab_3_hold_timer.sv - per-vector hold counter, expire flags the sample cycle
module lab_3_hold_timer #(
   parameter int HOLD_CYCLES = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int TW = $clog2(HOLD_CYCLES);
   localparam logic [TW-1:0] LAST = TW'(HOLD_CYCLES - 1);

   logic [TW-1:0] cnt;

   // wraps to zero on the sample edge so the next vector starts a fresh hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= expire ? '0 : cnt + TW'(1);
      end
   end

   assign expire = (cnt == LAST);

endmodule

// File: rtl/lab_3_bist.sv
// rtl/lab_3_bist.sv - exhaustive self-test sequencer and checker for lab_3
module lab_3_bist
   import lab_3_pkg::*;
#(
   parameter int         HOLD_CYCLES = 10,
   parameter logic [7:0] EXP_X       = 8'b1110_1000,
   parameter logic [7:0] EXP_Y       = 8'b1001_0110
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   lab_3_if.master          dut,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic             fail_valid,
   output logic [VEC_W-1:0] first_fail_idx
);

   state_t           state;
   state_t           next_state;
   logic [VEC_W-1:0] idx;
   logic [VEC_W-1:0] idx_nxt;
   logic [VEC_W-1:0] drive_q;
   logic [VEC_W-1:0] drive_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             expire;
   logic             accept;
   logic             sample;
   logic             last_vec;
   logic             miss;

   assign accept   = start && (state != RUN);
   assign sample   = (state == RUN) && expire;
   assign last_vec = (idx == VEC_W'(NUM_VECTORS - 1));
   assign miss     = (dut.x != EXP_X[idx]) || (dut.y != EXP_Y[idx]);

   lab_3_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept),
      .en     (state == RUN),
      .expire (expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (sample && last_vec) next_state = DONE;
         DONE:    if (start) next_state = RUN;
         default: next_state = IDLE;
      endcase
   end

   // outputs are decoded from the next state and registered so a,b,c never glitch
   always_comb begin
      idx_nxt = idx;
      if (accept) begin
         idx_nxt = '0;
      end else if (sample && !last_vec) begin
         idx_nxt = idx + VEC_W'(1);
      end
      busy_nxt  = (next_state == RUN);
      done_nxt  = (next_state == DONE);
      drive_nxt = busy_nxt ? idx_nxt : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= '0;
         drive_q <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         idx     <= idx_nxt;
         drive_q <= drive_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
      end
   end

   // a vector with both x and y wrong still counts as a single failure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count      <= '0;
         fail_valid     <= 1'b0;
         first_fail_idx <= '0;
      end else if (accept) begin
         err_count      <= '0;
         fail_valid     <= 1'b0;
         first_fail_idx <= '0;
      end else if (sample && miss) begin
         err_count <= err_count + CNT_W'(1);
         if (!fail_valid) begin
            fail_valid     <= 1'b1;
            first_fail_idx <= idx;
         end
      end
   end

   assign dut.a = drive_q[2];
   assign dut.b = drive_q[1];
   assign dut.c = drive_q[0];
   assign pass  = done && (err_count == '0);

endmodule

// File: doc/lab_3_bist.md
Name: lab_3_bist

Overview:
- Built-in self-test sequencer for the 3-input/2-output lab_3 combinational block; hardware counterpart of the bench stimulus/monitor loop.
- Drives a,b,c through all 8 combinations (000..111, a = MSB) and holds each for HOLD_CYCLES clocks.
- Samples x,y at the end of each hold and compares them against parameterised golden truth tables.
- Reports busy/done, pass, mismatch count and first failing vector; sits between a lab_3 instance and board LEDs/switches.

Parameters:
- HOLD_CYCLES, 10, clocks each vector is held before sampling; legal range >= 2.
- EXP_X, 8'b1110_1000, golden x per vector; bit i = expected x for {a,b,c} = i.
- EXP_Y, 8'b1001_0110, golden y per vector; bit i = expected y for {a,b,c} = i.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  level-sampled request to begin a run.
- a  output  1  stimulus to DUT, idx[2].
- b  output  1  stimulus to DUT, idx[1].
- c  output  1  stimulus to DUT, idx[0].
- x  input  1  DUT response.
- y  input  1  DUT response.
- busy  output  1  high while sequencing.
- done  output  1  high from run completion until next accepted start.
- pass  output  1  done && err_count == 0.
- err_count  output  4  number of mismatching vectors, 0..8.
- fail_valid  output  1  at least one mismatch recorded this run.
- first_fail_idx  output  3  index of the first mismatching vector; 0 if none.

Behaviour:
- Reset (async, immediate): state IDLE; a,b,c,busy,done,pass,fail_valid = 0; err_count = 0; first_fail_idx = 0; idx = 0; hold_cnt = 0.
- States:
  - IDLE: start=1 at an edge -> RUN. Clear err_count, fail_valid, first_fail_idx; set idx = 0, hold_cnt = 0.
  - RUN: busy=1; {a,b,c} = idx.
    - hold_cnt < HOLD_CYCLES-1: hold_cnt++.
    - hold_cnt == HOLD_CYCLES-1 (sample edge): compare x vs EXP_X[idx] and y vs EXP_Y[idx].
      - Any difference: err_count++. If fail_valid was 0, set fail_valid=1 and first_fail_idx=idx.
      - Then, if idx == 7 -> DONE; else idx++, hold_cnt = 0.
  - DONE: busy=0; done=1; {a,b,c} = 000; results held stable. start=1 -> RUN with the same clearing as from IDLE (restart).
- Each vector is driven for exactly HOLD_CYCLES cycles. done rises 8*HOLD_CYCLES edges after the start-acceptance edge.
- One mismatch is counted per vector; an x and y mismatch on the same vector counts once. No saturation needed (max 8 fits in 4 bits).
- start during RUN is ignored; no abort.
- pass is combinational from done and err_count; all other outputs are registered.
- a,b,c are 0 in IDLE and DONE; they change only at vector boundaries in RUN (glitch-free registered outputs).
- x,y are sampled directly at the sample edge. The DUT is combinational and the settle time is the HOLD_CYCLES-1 preceding cycles; no synchroniser is required.
- Reset mid-RUN: immediate return to IDLE and all outputs cleared; partial results are discarded.

Decomposition:
- Package lab_3_pkg:
  - state enum {IDLE, RUN, DONE}.
  - NUM_VECTORS = 8.
  - VEC_W = 3.
  - CNT_W = 4.
- One natural sub-module: lab_3_hold_timer. Parameterised HOLD_CYCLES, inputs clk/rst/clear/en, output `expire` asserted on the final hold cycle. Top-level FSM, index counter and result registers stay in lab_3_bist.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, start=0 -> all outputs 0, a,b,c = 000, busy=0 for 20 cycles.
- Golden DUT: lab_3_bist wired to a model matching EXP_X/EXP_Y, HOLD_CYCLES=10, start pulse -> busy for 80 cycles; {a,b,c} steps 000..111 every 10 cycles; done=1, pass=1, err_count=0, fail_valid=0.
- Faulty DUT, y stuck-at-0: EXP_Y=8'b1001_0110 -> err_count=4, fail_valid=1, first_fail_idx=1, pass=0.
- Double fault on one vector: x and y both inverted only for idx 5 -> err_count=1 (not 2), first_fail_idx=5.
- start held high during RUN, then a restart from DONE with a now-golden DUT -> mid-run start ignored (still 80 cycles); second run clears results, ends pass=1, err_count=0.
- Async reset at cycle 35 of a run -> outputs 0 before the next clock edge; a subsequent start runs a full 80-cycle sequence from idx 0.
